uart_word_assembler: RTL and testbench
======================================

UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 8: bytes per assembled word, legal range 2..16.
REQ-002 The block SHALL have parameter TIMEOUT_CLKS, default 1250000: idle clocks before a partial word is discarded; 0 disables the timeout.
REQ-003 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_Rx_DV, input, 1 bit: one-cycle byte strobe from the UART receiver.
REQ-006 The block SHALL have port i_Rx_Byte, input, 8 bits: received byte, valid while i_Rx_DV is high.
REQ-007 The block SHALL have port o_Word, output, 8*NUM_BYTES bits: assembled word.
REQ-008 The block SHALL have port o_Word_Valid, output, 1 bit: o_Word is complete and held.
REQ-009 The block SHALL have port i_Word_Ready, input, 1 bit: the consumer accepts o_Word.
REQ-010 The block SHALL have port o_Byte_Count, output, 5 bits: bytes collected in the current word.
REQ-011 The block SHALL have port o_Overrun, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-012 The block SHALL have port o_Timeout, output, 1 bit: one-cycle pulse when a partial word is discarded.

Function
REQ-013 The block SHALL have exactly two states: COLLECT and HOLD.
REQ-014 In COLLECT, each i_Rx_DV SHALL shift the word register left by 8 and load i_Rx_Byte into bits [7:0], so that the first byte ends up in the MS byte.
REQ-015 In COLLECT, each i_Rx_DV SHALL increment o_Byte_Count.
REQ-016 On the NUM_BYTES-th byte, the block SHALL enter HOLD, with o_Word_Valid high on the cycle after that i_Rx_DV and o_Byte_Count = NUM_BYTES.
REQ-017 In HOLD, o_Word and o_Word_Valid SHALL stay stable until i_Word_Ready is sampled high.
REQ-018 A handshake (HOLD and i_Word_Ready high) SHALL return the block to COLLECT with o_Byte_Count = 0 and o_Word_Valid low on the next cycle.
REQ-019 i_Word_Ready SHALL be ignored in COLLECT.
REQ-020 i_Rx_DV in HOLD without a handshake SHALL drop the byte, leave o_Word unchanged, and pulse o_Overrun for one cycle.
REQ-021 i_Rx_DV in the same cycle as a handshake SHALL be accepted as the first byte of the next word: COLLECT, o_Byte_Count = 1, no o_Overrun.
REQ-022 In COLLECT with o_Byte_Count > 0 and TIMEOUT_CLKS > 0, an idle counter SHALL increment on every cycle without i_Rx_DV and clear on every accepted byte.
REQ-023 When the idle counter reaches TIMEOUT_CLKS-1, the block SHALL clear o_Byte_Count, the word register and the counter, and pulse o_Timeout for one cycle.
REQ-024 i_Rx_DV on the expiry cycle SHALL win: the byte is accepted, the counter clears, and there is no o_Timeout pulse.
REQ-025 The idle counter SHALL be held at 0 in HOLD and whenever o_Byte_Count = 0.
REQ-026 The idle counter SHALL be sized with clog2(TIMEOUT_CLKS+1) bits, saturating, and SHALL never wrap.
REQ-027 The block SHALL have no combinational path from any input to any output; all outputs are registered.

Reset
REQ-028 Assertion of i_Rst_n low SHALL immediately force COLLECT, o_Word = 0, o_Word_Valid = 0, o_Byte_Count = 0, o_Overrun = 0, o_Timeout = 0, and idle counter = 0, independent of i_Clock.
REQ-029 Reset asserted mid-word or in HOLD SHALL discard all collected data; the first i_Rx_DV after release SHALL count as byte 1.

Verification
REQ-030 Bytes 0x01..0x08 sent with gaps, i_Word_Ready low -> o_Word = 0x0102030405060708 and o_Word_Valid high one cycle after the 8th strobe, both held for 100 cycles.
REQ-031 In HOLD with i_Word_Ready low, i_Rx_DV with 0xAA -> one o_Overrun pulse, o_Word unchanged, o_Byte_Count = 8.
REQ-032 In HOLD, i_Word_Ready and i_Rx_DV with 0x55 in the same cycle -> next cycle o_Word_Valid = 0, o_Byte_Count = 1, o_Word[7:0] = 0x55.
REQ-033 Bytes 0x11, 0x22, 0x33, then idle with TIMEOUT_CLKS = 50 -> o_Timeout pulses 50 cycles after the last strobe, o_Byte_Count = 0; 8 new bytes then yield a clean word.
REQ-034 Byte arriving exactly on the expiry cycle (TIMEOUT_CLKS = 50) -> no o_Timeout, o_Byte_Count = 4.
REQ-035 i_Rst_n pulsed low between clock edges after 5 bytes -> all outputs 0 before the next edge; 8 bytes 0xA0..0xA7 then give o_Word = 0xA0A1A2A3A4A5A6A7.

Source files
------------

// File: rtl/uart_word_assembler_if.sv
// Bundles the byte stream from the UART receiver, the word hand-off and
// the status pulses of uart_word_assembler.
//
// Signal roles:
//   i_Rx_DV / i_Rx_Byte  One-cycle byte strobe from the receiver. There is
//                        no back-pressure, so a byte that cannot be taken
//                        is dropped and flagged on o_Overrun.
//   o_Word / o_Word_Valid / i_Word_Ready
//                        A valid/ready pair. Once o_Word_Valid rises,
//                        o_Word stays frozen until i_Word_Ready is sampled
//                        high on a rising clock edge. That edge completes
//                        the transfer.
//   o_Byte_Count         Number of bytes gathered into the current word.
//   o_Overrun / o_Timeout
//                        Single-cycle event pulses.
//   dbg_state            Current state of the control FSM (0 = COLLECT,
//                        1 = HOLD). It lets checkers bind to the FSM.
//
// The master modport is the assembler itself. The slave modport is the
// surrounding logic, which supplies the bytes and consumes the words.
interface uart_word_assembler_if #(
  parameter int NUM_BYTES = 8
);
  logic                   i_Rx_DV;
  logic [7:0]             i_Rx_Byte;
  logic [8*NUM_BYTES-1:0] o_Word;
  logic                   o_Word_Valid;
  logic                   i_Word_Ready;
  logic [4:0]             o_Byte_Count;
  logic                   o_Overrun;
  logic                   o_Timeout;
  logic                   dbg_state;

  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Word_Ready,
    output o_Word, o_Word_Valid, o_Byte_Count, o_Overrun, o_Timeout, dbg_state
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Word_Ready,
    input  o_Word, o_Word_Valid, o_Byte_Count, o_Overrun, o_Timeout, dbg_state
  );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs UART bytes into NUM_BYTES-wide words. The first byte received ends
// up in the most-significant byte of the word. A finished word is held
// until it is accepted. Bytes that arrive while a word is held are dropped.
// A partial word that sits idle for TIMEOUT_CLKS clocks is discarded.
module uart_word_assembler #(
  parameter int NUM_BYTES    = 8,
  parameter int TIMEOUT_CLKS = 1250000
) (
  input logic                    i_Clock,
  input logic                    i_Rst_n,
  uart_word_assembler_if.master  bus
);

  localparam int W      = 8 * NUM_BYTES;
  // At least one bit, so that the counter is still legal when the timeout
  // is disabled.
  localparam int IDLE_W = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    (TIMEOUT_CLKS > 0) ? IDLE_W'(TIMEOUT_CLKS - 1) : '0;
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [4:0]        LAST_BYTE = 5'(NUM_BYTES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t            state;
  logic [W-1:0]      word;
  logic              word_valid;
  logic [4:0]        byte_count;
  logic              overrun;
  logic              timeout;
  logic [IDLE_W-1:0] idle_cnt;

  // Control FSM, word shifter, idle counter and event pulses. Every output
  // is driven from a register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= COLLECT;
      word       <= '0;
      word_valid <= 1'b0;
      byte_count <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.i_Rx_DV) begin
            // An incoming byte always beats an expiring timeout.
            word       <= {word[W-9:0], bus.i_Rx_Byte};
            byte_count <= byte_count + 5'd1;
            idle_cnt   <= '0;
            if (byte_count == LAST_BYTE) begin
              state      <= HOLD;
              word_valid <= 1'b1;
            end
          end else if (TIMEOUT_CLKS > 0 && byte_count != 5'd0) begin
            if (idle_cnt == IDLE_LAST) begin
              word       <= '0;
              byte_count <= '0;
              idle_cnt   <= '0;
              timeout    <= 1'b1;
            end else if (idle_cnt != {IDLE_W{1'b1}}) begin
              idle_cnt <= idle_cnt + IDLE_ONE;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        HOLD: begin
          idle_cnt <= '0;
          if (bus.i_Word_Ready) begin
            // Handshake. A byte arriving in the same cycle opens the
            // next word.
            state      <= COLLECT;
            word_valid <= 1'b0;
            if (bus.i_Rx_DV) begin
              word       <= {{(W-8){1'b0}}, bus.i_Rx_Byte};
              byte_count <= 5'd1;
            end else begin
              word       <= '0;
              byte_count <= '0;
            end
          end else if (bus.i_Rx_DV) begin
            overrun <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.o_Word       = word;
  assign bus.o_Word_Valid = word_valid;
  assign bus.o_Byte_Count = byte_count;
  assign bus.o_Overrun    = overrun;
  assign bus.o_Timeout    = timeout;
  assign bus.dbg_state    = (state == HOLD);

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler (NUM_BYTES = 8, TIMEOUT_CLKS = 50).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle after the rising edge that updated them.
module tb_uart_word_assembler;

  localparam int NB = 8;
  localparam int TO = 50;

  logic i_Clock;
  logic i_Rst_n;

  uart_word_assembler_if #(.NUM_BYTES(NB)) bus ();

  uart_word_assembler #(
    .NUM_BYTES   (NB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .bus    (bus.master)
  );

  // Clock and reset
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_word;

  // Scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks. Each one is entered and left at a falling edge.
  task automatic strobe(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge i_Clock);
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic handshake();
    bus.i_Word_Ready = 1'b1;
    @(negedge i_Clock);
    bus.i_Word_Ready = 1'b0;
  endtask

  task automatic check_word(input string tag);
    exp_word = exp_q.pop_front();
    check({tag, "_word"}, bus.o_Word, exp_word);
    check({tag, "_valid"}, {63'd0, bus.o_Word_Valid}, 64'd1);
    check({tag, "_count"}, {59'd0, bus.o_Byte_Count}, 64'd8);
    check({tag, "_state"}, {63'd0, bus.dbg_state}, 64'd1);
  endtask

  logic       stable;
  logic       saw_to;
  logic [7:0] b8;

  initial begin
    i_Rst_n          = 1'b0;
    bus.i_Rx_DV      = 1'b0;
    bus.i_Rx_Byte    = 8'h00;
    bus.i_Word_Ready = 1'b0;
    idle(2);
    check("rst_word",  bus.o_Word, 64'd0);
    check("rst_valid", {63'd0, bus.o_Word_Valid}, 64'd0);
    check("rst_count", {59'd0, bus.o_Byte_Count}, 64'd0);
    check("rst_ovr",   {63'd0, bus.o_Overrun}, 64'd0);
    check("rst_to",    {63'd0, bus.o_Timeout}, 64'd0);
    i_Rst_n = 1'b1;
    idle(2);

    // Bytes 01..08 with gaps, then held for 100 cycles without Ready
    exp_q.push_back(64'h0102030405060708);
    for (int i = 1; i <= 8; i++) begin
      b8 = 8'(i);
      strobe(b8);
      if (i == 1) check("cnt_after_1", {59'd0, bus.o_Byte_Count}, 64'd1);
      if (i == 5) check("cnt_after_5", {59'd0, bus.o_Byte_Count}, 64'd5);
      if (i == 7) check("valid_before_8", {63'd0, bus.o_Word_Valid}, 64'd0);
      if (i < 8) idle(3);
    end
    check_word("w1");
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (bus.o_Word !== 64'h0102030405060708 || bus.o_Word_Valid !== 1'b1) stable = 1'b0;
    end
    check("w1_hold100", {63'd0, stable}, 64'd1);

    // Overrun: a byte arriving in HOLD without Ready is dropped
    strobe(8'hAA);
    check("ovr_pulse", {63'd0, bus.o_Overrun}, 64'd1);
    check("ovr_word",  bus.o_Word, 64'h0102030405060708);
    check("ovr_count", {59'd0, bus.o_Byte_Count}, 64'd8);
    idle(1);
    check("ovr_1cyc",  {63'd0, bus.o_Overrun}, 64'd0);

    // Handshake together with a byte: the byte starts the next word
    bus.i_Word_Ready = 1'b1;
    strobe(8'h55);
    bus.i_Word_Ready = 1'b0;
    check("hs_valid", {63'd0, bus.o_Word_Valid}, 64'd0);
    check("hs_count", {59'd0, bus.o_Byte_Count}, 64'd1);
    check("hs_lsb",   {56'd0, bus.o_Word[7:0]}, 64'h55);
    check("hs_ovr",   {63'd0, bus.o_Overrun}, 64'd0);
    exp_q.push_back(64'h55565758595A5B5C);
    for (int i = 1; i < 8; i++) begin
      b8 = 8'(8'h55 + i);
      strobe(b8);
    end
    check_word("w2");
    handshake();
    check("w2_ack_valid", {63'd0, bus.o_Word_Valid}, 64'd0);
    check("w2_ack_count", {59'd0, bus.o_Byte_Count}, 64'd0);

    // Ready is ignored in COLLECT, and there is no timeout while empty
    saw_to = 1'b0;
    bus.i_Word_Ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      if (bus.o_Timeout !== 1'b0) saw_to = 1'b1;
    end
    check("no_to_empty", {63'd0, saw_to}, 64'd0);
    strobe(8'h11);
    bus.i_Word_Ready = 1'b0;
    check("rdy_ign_count", {59'd0, bus.o_Byte_Count}, 64'd1);
    check("rdy_ign_state", {63'd0, bus.dbg_state}, 64'd0);

    // Timeout 50 cycles after the last strobe
    strobe(8'h22);
    strobe(8'h33);
    idle(TO - 1);
    check("to_early",  {63'd0, bus.o_Timeout}, 64'd0);
    check("to_early_cnt", {59'd0, bus.o_Byte_Count}, 64'd3);
    idle(1);
    check("to_pulse",  {63'd0, bus.o_Timeout}, 64'd1);
    check("to_count",  {59'd0, bus.o_Byte_Count}, 64'd0);
    check("to_word",   bus.o_Word, 64'd0);
    idle(1);
    check("to_1cyc",   {63'd0, bus.o_Timeout}, 64'd0);
    exp_q.push_back(64'hC0C1C2C3C4C5C6C7);
    for (int i = 0; i < 8; i++) begin
      b8 = 8'(8'hC0 + i);
      strobe(b8);
    end
    check_word("w3");
    handshake();

    // A byte exactly on the expiry cycle wins over the timeout
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    idle(TO - 1);
    strobe(8'h44);
    check("exp_to",    {63'd0, bus.o_Timeout}, 64'd0);
    check("exp_count", {59'd0, bus.o_Byte_Count}, 64'd4);
    check("exp_word",  bus.o_Word, 64'h11223344);
    idle(1);
    check("exp_to_next", {63'd0, bus.o_Timeout}, 64'd0);
    exp_q.push_back(64'h1122334455667788);
    strobe(8'h55);
    strobe(8'h66);
    strobe(8'h77);
    strobe(8'h88);
    check_word("w4");
    handshake();

    // Asynchronous reset mid-word, pulsed between clock edges
    for (int i = 0; i < 5; i++) begin
      b8 = 8'(8'hE0 + i);
      strobe(b8);
    end
    check("pre_rst_count", {59'd0, bus.o_Byte_Count}, 64'd5);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("arst_word",  bus.o_Word, 64'd0);
    check("arst_count", {59'd0, bus.o_Byte_Count}, 64'd0);
    check("arst_valid", {63'd0, bus.o_Word_Valid}, 64'd0);
    check("arst_flags", {62'd0, bus.o_Overrun, bus.o_Timeout}, 64'd0);
    #1;
    i_Rst_n = 1'b1;
    @(negedge i_Clock);
    exp_q.push_back(64'hA0A1A2A3A4A5A6A7);
    for (int i = 0; i < 8; i++) begin
      b8 = 8'(8'hA0 + i);
      strobe(b8);
      if (i == 0) check("post_rst_cnt1", {59'd0, bus.o_Byte_Count}, 64'd1);
    end
    check_word("w5");
    handshake();
    check("end_count", {59'd0, bus.o_Byte_Count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
